// File: rtl/mc_control_seq_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: state codes,
// datapath select codes, exception causes and the opcode/funct values it decodes.
package mc_ctrl_pkg;

   typedef enum logic [5:0] {
      S_RESET     = 6'd0,
      S_FETCH     = 6'd1,
      S_DECODE    = 6'd2,
      S_R_EXEC    = 6'd3,
      S_R_WB      = 6'd4,
      S_ADDI_EXEC = 6'd5,
      S_I_WB      = 6'd6,
      S_BRANCH    = 6'd7,
      S_J         = 6'd8,
      S_JAL       = 6'd9,
      S_JR        = 6'd10,
      S_MEM_ADDR  = 6'd11,
      S_MEM_RD    = 6'd12,
      S_LW_WB     = 6'd13,
      S_MEM_WR    = 6'd14,
      S_MD_START  = 6'd15,
      S_MD_WAIT   = 6'd16,
      S_MF_WB     = 6'd17,
      S_EXC       = 6'd18
   } state_e;

   localparam logic [2:0] ALU_PASS_A = 3'd0;
   localparam logic [2:0] ALU_ADD    = 3'd1;
   localparam logic [2:0] ALU_SUB    = 3'd2;
   localparam logic [2:0] ALU_AND    = 3'd3;
   localparam logic [2:0] ALU_SLT    = 3'd4;
   localparam logic [2:0] ALU_SLL    = 3'd5;
   localparam logic [2:0] ALU_SRL    = 3'd6;
   localparam logic [2:0] ALU_SRA    = 3'd7;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] MTR_ALUOUT = 2'd0;
   localparam logic [1:0] MTR_MDR    = 2'd1;
   localparam logic [1:0] MTR_HI     = 2'd2;
   localparam logic [1:0] MTR_LO     = 2'd3;

   localparam logic [1:0] CAUSE_BAD_OP = 2'd0;
   localparam logic [1:0] CAUSE_OVF    = 2'd1;
   localparam logic [1:0] CAUSE_DIV0   = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_SLT:  return ALU_SLT;
         FN_SLL:  return ALU_SLL;
         FN_SRL:  return ALU_SRL;
         FN_SRA:  return ALU_SRA;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_seq_if.sv
// Control/status bundle between the sequencer (master) and the MIPS datapath (slave).
interface mc_control_seq_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;
   logic       div0;

   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       mem_read;
   logic       mem_write;
   logic       iord;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       alu_out_write;
   logic       ab_write;
   logic       mdr_write;
   logic       hilo_write;
   logic       epc_write;
   logic       muldiv_start;
   logic       muldiv_op;
   logic [1:0] cause;
   logic [5:0] state;

   modport master (
      input  opcode, funct, zero, overflow, div0,
      output pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, alu_out_write,
             ab_write, mdr_write, hilo_write, epc_write, muldiv_start, muldiv_op,
             cause, state
   );

   modport slave (
      output opcode, funct, zero, overflow, div0,
      input  pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, alu_out_write,
             ab_write, mdr_write, hilo_write, epc_write, muldiv_start, muldiv_op,
             cause, state
   );
endinterface

// File: rtl/mc_control_seq.sv
// Multicycle MIPS control sequencer with parametrised memory and mult/div latency.
// Define MC_SEQ_OVF_TRAP_EN to trap signed overflow on add/sub/addi (cause 1).
module mc_control_seq
   import mc_ctrl_pkg::*;
#(
   parameter int         MEM_WAIT       = 1,
   parameter int         MULDIV_CYCLES  = 32,
   parameter logic [1:0] EXC_VECTOR_SEL = 2'd3
) (
   input  logic              clock,
   input  logic              reset_n,
   mc_control_seq_if.master  ctl
);

   localparam logic [5:0] MEM_LAST = 6'(MEM_WAIT);
   localparam logic [5:0] MD_LAST  = 6'(MULDIV_CYCLES - 1);

   state_e     state_q, state_d;
   logic [5:0] wait_cnt;
   logic [1:0] cause_q, cause_d;
   logic       is_div;
   logic       mem_last, md_last;

   assign is_div   = (ctl.funct == FN_DIV);
   assign mem_last = (wait_cnt == MEM_LAST);
   assign md_last  = (wait_cnt == MD_LAST);

   // The single wait counter restarts whenever the state changes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_RESET;
         wait_cnt <= '0;
         cause_q  <= CAUSE_BAD_OP;
      end else begin
         state_q  <= state_d;
         wait_cnt <= (state_d != state_q) ? 6'd0 : wait_cnt + 6'd1;
         if (state_d == S_EXC) cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = CAUSE_BAD_OP;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  if (mem_last) state_d = S_DECODE;
         S_DECODE: begin
            case (ctl.opcode)
               OP_RTYPE: begin
                  case (ctl.funct)
                     FN_ADD, FN_SUB, FN_AND, FN_SLT,
                     FN_SLL, FN_SRL, FN_SRA:  state_d = S_R_EXEC;
                     FN_MULT, FN_DIV:         state_d = S_MD_START;
                     FN_MFHI, FN_MFLO:        state_d = S_MF_WB;
                     FN_JR:                   state_d = S_JR;
                     default:                 state_d = S_EXC;
                  endcase
               end
               OP_ADDI:        state_d = S_ADDI_EXEC;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_J;
               OP_JAL:         state_d = S_JAL;
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               default:        state_d = S_EXC;
            endcase
         end
`ifdef MC_SEQ_OVF_TRAP_EN
         S_R_EXEC: begin
            if ((ctl.funct == FN_ADD || ctl.funct == FN_SUB) && ctl.overflow) begin
               state_d = S_EXC;
               cause_d = CAUSE_OVF;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_ADDI_EXEC: begin
            if (ctl.overflow) begin
               state_d = S_EXC;
               cause_d = CAUSE_OVF;
            end else begin
               state_d = S_I_WB;
            end
         end
`else
         S_R_EXEC:    state_d = S_R_WB;
         S_ADDI_EXEC: state_d = S_I_WB;
`endif
         S_MEM_ADDR: state_d = (ctl.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_last) state_d = S_LW_WB;
         S_MEM_WR:   if (mem_last) state_d = S_FETCH;
         S_MD_START: begin
            if (is_div && ctl.div0) begin
               state_d = S_EXC;
               cause_d = CAUSE_DIV0;
            end else begin
               state_d = S_MD_WAIT;
            end
         end
         S_MD_WAIT:  if (md_last) state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

`ifndef MC_SEQ_OVF_TRAP_EN
   logic unused_overflow;
   assign unused_overflow = ctl.overflow;
`endif

   always_comb begin
      ctl.pc_write      = 1'b0;
      ctl.pc_src        = PC_SRC_ALU;
      ctl.ir_write      = 1'b0;
      ctl.mem_read      = 1'b0;
      ctl.mem_write     = 1'b0;
      ctl.iord          = 1'b0;
      ctl.reg_write     = 1'b0;
      ctl.reg_dst       = REG_DST_RT;
      ctl.mem_to_reg    = MTR_ALUOUT;
      ctl.alu_src_a     = 1'b0;
      ctl.alu_src_b     = 2'd0;
      ctl.alu_op        = ALU_PASS_A;
      ctl.alu_out_write = 1'b0;
      ctl.ab_write      = 1'b0;
      ctl.mdr_write     = 1'b0;
      ctl.hilo_write    = 1'b0;
      ctl.epc_write     = 1'b0;
      ctl.muldiv_start  = 1'b0;
      ctl.muldiv_op     = 1'b0;
      ctl.cause         = CAUSE_BAD_OP;
      ctl.state         = state_q;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read = 1'b1;
            if (mem_last) begin
               ctl.ir_write  = 1'b1;
               ctl.pc_write  = 1'b1;
               ctl.alu_src_b = 2'd1;
               ctl.alu_op    = ALU_ADD;
            end
         end
         S_DECODE: begin
            ctl.ab_write      = 1'b1;
            ctl.alu_out_write = 1'b1;
            ctl.alu_src_b     = 2'd3;
            ctl.alu_op        = ALU_ADD;
         end
         S_R_EXEC: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_op        = funct_alu_op(ctl.funct);
            ctl.alu_out_write = 1'b1;
         end
         S_ADDI_EXEC, S_MEM_ADDR: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = 2'd2;
            ctl.alu_op        = ALU_ADD;
            ctl.alu_out_write = 1'b1;
         end
         S_R_WB: begin
            ctl.reg_dst   = REG_DST_RD;
            ctl.reg_write = 1'b1;
         end
         S_I_WB: ctl.reg_write = 1'b1;
         S_BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = ALU_SUB;
            ctl.pc_src    = PC_SRC_ALUOUT;
            ctl.pc_write  = ctl.zero ^ ctl.opcode[0];
         end
         S_J: begin
            ctl.pc_src   = PC_SRC_JUMP;
            ctl.pc_write = 1'b1;
         end
         S_JAL: begin
            ctl.reg_dst   = REG_DST_RA;
            ctl.reg_write = 1'b1;
            ctl.pc_src    = PC_SRC_JUMP;
            ctl.pc_write  = 1'b1;
         end
         S_JR: begin
            ctl.alu_src_a = 1'b1;
            ctl.pc_write  = 1'b1;
         end
         S_MEM_RD: begin
            ctl.mem_read  = 1'b1;
            ctl.iord      = 1'b1;
            ctl.mdr_write = mem_last;
         end
         S_LW_WB: begin
            ctl.mem_to_reg = MTR_MDR;
            ctl.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            ctl.mem_write = 1'b1;
            ctl.iord      = 1'b1;
         end
         // A divide by zero never starts the unit; the EXC state follows.
         S_MD_START: begin
            ctl.muldiv_op    = is_div;
            ctl.muldiv_start = !(is_div && ctl.div0);
         end
         S_MD_WAIT: ctl.hilo_write = md_last;
         S_MF_WB: begin
            ctl.mem_to_reg = (ctl.funct == FN_MFHI) ? MTR_HI : MTR_LO;
            ctl.reg_dst    = REG_DST_RD;
            ctl.reg_write  = 1'b1;
         end
         S_EXC: begin
            ctl.epc_write = 1'b1;
            ctl.cause     = cause_q;
            ctl.pc_src    = EXC_VECTOR_SEL;
            ctl.pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_seq.sv
// Self-checking bench for mc_control_seq: per-instruction expected control traces,
// a directed table, randomized instructions and multi-cycle reset/latency sequences.
module tb_mc_control_seq;
   import mc_ctrl_pkg::*;

   localparam int MW = 3;
   localparam int MD = 32;
`ifdef MC_SEQ_OVF_TRAP_EN
   localparam bit OVF_TRAP = 1'b1;
`else
   localparam bit OVF_TRAP = 1'b0;
`endif

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       alu_out_write;
      logic       ab_write;
      logic       mdr_write;
      logic       hilo_write;
      logic       epc_write;
      logic       muldiv_start;
      logic       muldiv_op;
      logic [1:0] cause;
   } ctrl_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       ov;
      logic       d0;
      int         n_pcw;
      int         n_rw;
      int         ecause;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad = 0;
   ctrl_t exp_q[$];
   ctrl_t act;
   vec_t  tab[$];

   mc_control_seq_if ctl();

   mc_control_seq #(.MEM_WAIT(MW), .MULDIV_CYCLES(MD), .EXC_VECTOR_SEL(2'd3)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .ctl     (ctl)
   );

   always #5 clock = ~clock;

   always_comb begin
      act.pc_write      = ctl.pc_write;
      act.pc_src        = ctl.pc_src;
      act.ir_write      = ctl.ir_write;
      act.mem_read      = ctl.mem_read;
      act.mem_write     = ctl.mem_write;
      act.iord          = ctl.iord;
      act.reg_write     = ctl.reg_write;
      act.reg_dst       = ctl.reg_dst;
      act.mem_to_reg    = ctl.mem_to_reg;
      act.alu_src_a     = ctl.alu_src_a;
      act.alu_src_b     = ctl.alu_src_b;
      act.alu_op        = ctl.alu_op;
      act.alu_out_write = ctl.alu_out_write;
      act.ab_write      = ctl.ab_write;
      act.mdr_write     = ctl.mdr_write;
      act.hilo_write    = ctl.hilo_write;
      act.epc_write     = ctl.epc_write;
      act.muldiv_start  = ctl.muldiv_start;
      act.muldiv_op     = ctl.muldiv_op;
      act.cause         = ctl.cause;
   end

   task automatic check_vec(input string nm, input ctrl_t got, input ctrl_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %07h want %07h", nm, got, want);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      logic [2:0] r;
      r = 3'd1;
      if (fn == 6'h22) r = 3'd2;
      if (fn == 6'h24) r = 3'd3;
      if (fn == 6'h2A) r = 3'd4;
      if (fn == 6'h00) r = 3'd5;
      if (fn == 6'h02) r = 3'd6;
      if (fn == 6'h03) r = 3'd7;
      return r;
   endfunction

   task automatic push_exc(input logic [1:0] cs);
      ctrl_t c;
      c = '0;
      c.epc_write = 1'b1;
      c.cause     = cs;
      c.pc_src    = 2'd3;
      c.pc_write  = 1'b1;
      exp_q.push_back(c);
   endtask

   // Expected per-cycle control trace of one whole instruction, FETCH onward.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic ov, input logic d0);
      ctrl_t c;
      bit    trap;
      exp_q.delete();
      for (int k = 0; k <= MW; k++) begin
         c = '0;
         c.mem_read = 1'b1;
         if (k == MW) begin
            c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 3'd1;
         end
         exp_q.push_back(c);
      end
      c = '0;
      c.ab_write = 1'b1; c.alu_out_write = 1'b1; c.alu_src_b = 2'd3; c.alu_op = 3'd1;
      exp_q.push_back(c);
      if (op == 6'h00) begin
         case (fn)
            6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h02, 6'h03: begin
               c = '0;
               c.alu_src_a = 1'b1; c.alu_op = r_alu(fn); c.alu_out_write = 1'b1;
               exp_q.push_back(c);
               trap = OVF_TRAP && ov && (fn == 6'h20 || fn == 6'h22);
               if (trap) push_exc(2'd1);
               else begin
                  c = '0; c.reg_dst = 2'd1; c.reg_write = 1'b1; exp_q.push_back(c);
               end
            end
            6'h18, 6'h1A: begin
               c = '0;
               c.muldiv_op    = (fn == 6'h1A);
               c.muldiv_start = !(fn == 6'h1A && d0);
               exp_q.push_back(c);
               if (fn == 6'h1A && d0) push_exc(2'd2);
               else begin
                  c = '0;
                  for (int k = 1; k < MD; k++) exp_q.push_back(c);
                  c.hilo_write = 1'b1;
                  exp_q.push_back(c);
               end
            end
            6'h10, 6'h12: begin
               c = '0;
               c.mem_to_reg = (fn == 6'h10) ? 2'd2 : 2'd3;
               c.reg_dst = 2'd1; c.reg_write = 1'b1;
               exp_q.push_back(c);
            end
            6'h08: begin
               c = '0; c.alu_src_a = 1'b1; c.pc_write = 1'b1; exp_q.push_back(c);
            end
            default: push_exc(2'd0);
         endcase
      end else begin
         case (op)
            6'h08: begin
               c = '0;
               c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd1; c.alu_out_write = 1'b1;
               exp_q.push_back(c);
               if (OVF_TRAP && ov) push_exc(2'd1);
               else begin
                  c = '0; c.reg_write = 1'b1; exp_q.push_back(c);
               end
            end
            6'h04, 6'h05: begin
               c = '0;
               c.alu_src_a = 1'b1; c.alu_op = 3'd2; c.pc_src = 2'd1;
               c.pc_write = (op == 6'h05) ? !z : z;
               exp_q.push_back(c);
            end
            6'h02, 6'h03: begin
               c = '0;
               c.pc_src = 2'd2; c.pc_write = 1'b1;
               if (op == 6'h03) begin
                  c.reg_dst = 2'd2; c.reg_write = 1'b1;
               end
               exp_q.push_back(c);
            end
            6'h23, 6'h2B: begin
               c = '0;
               c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd1; c.alu_out_write = 1'b1;
               exp_q.push_back(c);
               for (int k = 0; k <= MW; k++) begin
                  c = '0;
                  c.iord = 1'b1;
                  if (op == 6'h23) begin
                     c.mem_read = 1'b1; c.mdr_write = (k == MW);
                  end else begin
                     c.mem_write = 1'b1;
                  end
                  exp_q.push_back(c);
               end
               if (op == 6'h23) begin
                  c = '0; c.mem_to_reg = 2'd1; c.reg_write = 1'b1; exp_q.push_back(c);
               end
            end
            default: push_exc(2'd0);
         endcase
      end
   endtask

   // Entered just after the edge that starts FETCH; leaves just after the next one.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic ov, input logic d0,
                            output int pcw, output int rw, output int ecause);
      build(op, fn, z, ov, d0);
      ctl.opcode = op; ctl.funct = fn; ctl.zero = z; ctl.overflow = ov; ctl.div0 = d0;
      pcw = 0; rw = 0; ecause = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clock);
         check_vec($sformatf("op%02h_fn%02h_z%0d_ov%0d_d%0d_cyc%0d", op, fn, z, ov, d0, k),
                   act, exp_q[k]);
         pcw += int'(act.pc_write);
         rw  += int'(act.reg_write);
         if (act.epc_write) ecause = int'(act.cause);
         @(posedge clock);
         #1;
      end
   endtask

   task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic ov, input logic d0,
                          input int npcw, input int nrw, input int ec);
      vec_t v;
      v.name = nm; v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.d0 = d0;
      v.n_pcw = npcw; v.n_rw = nrw; v.ecause = ec;
      tab.push_back(v);
   endtask

   initial begin
      logic [11:0] pool [0:19];
      int pcw, rw, ec, s, h;
      logic [5:0] op, fn;

      add_vec("add",      6'h00, 6'h20, 0, 0, 0, 1, 1, -1);
      add_vec("sub",      6'h00, 6'h22, 0, 0, 0, 1, 1, -1);
      add_vec("slt",      6'h00, 6'h2A, 0, 0, 0, 1, 1, -1);
      add_vec("sra",      6'h00, 6'h03, 0, 0, 0, 1, 1, -1);
      add_vec("and_ovf",  6'h00, 6'h24, 0, 1, 0, 1, 1, -1);
      if (OVF_TRAP) begin
         add_vec("add_ovf",  6'h00, 6'h20, 0, 1, 0, 2, 0, 1);
         add_vec("addi_ovf", 6'h08, 6'h00, 0, 1, 0, 2, 0, 1);
      end else begin
         add_vec("add_ovf",  6'h00, 6'h20, 0, 1, 0, 1, 1, -1);
         add_vec("addi_ovf", 6'h08, 6'h00, 0, 1, 0, 1, 1, -1);
      end
      add_vec("addi",     6'h08, 6'h11, 0, 0, 0, 1, 1, -1);
      add_vec("beq_z1",   6'h04, 6'h00, 1, 0, 0, 2, 0, -1);
      add_vec("beq_z0",   6'h04, 6'h00, 0, 0, 0, 1, 0, -1);
      add_vec("bne_z1",   6'h05, 6'h00, 1, 0, 0, 1, 0, -1);
      add_vec("bne_z0",   6'h05, 6'h00, 0, 0, 0, 2, 0, -1);
      add_vec("j",        6'h02, 6'h00, 0, 0, 0, 2, 0, -1);
      add_vec("jal",      6'h03, 6'h00, 0, 0, 0, 2, 1, -1);
      add_vec("jr",       6'h00, 6'h08, 0, 0, 0, 2, 0, -1);
      add_vec("lw",       6'h23, 6'h00, 0, 0, 0, 1, 1, -1);
      add_vec("sw",       6'h2B, 6'h00, 0, 0, 0, 1, 0, -1);
      add_vec("mfhi",     6'h00, 6'h10, 0, 0, 0, 1, 1, -1);
      add_vec("mflo",     6'h00, 6'h12, 0, 0, 0, 1, 1, -1);
      add_vec("mult",     6'h00, 6'h18, 0, 0, 0, 1, 0, -1);
      add_vec("div_ok",   6'h00, 6'h1A, 0, 0, 0, 1, 0, -1);
      add_vec("div_zero", 6'h00, 6'h1A, 0, 0, 1, 2, 0, 2);
      add_vec("bad_op",   6'h3F, 6'h00, 0, 0, 0, 2, 0, 0);
      add_vec("bad_fn",   6'h00, 6'h01, 0, 0, 0, 2, 0, 0);

      pool = '{12'h020, 12'h022, 12'h024, 12'h02A, 12'h000, 12'h002, 12'h003, 12'h018,
               12'h01A, 12'h010, 12'h012, 12'h008, 12'h200, 12'h100, 12'h140, 12'h080,
               12'h0C0, 12'h8C0, 12'hAC0, 12'hFC0};

      ctl.opcode = '0; ctl.funct = '0; ctl.zero = 0; ctl.overflow = 0; ctl.div0 = 0;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_vec("reset_outputs", act, '0);
      check_int("reset_state", int'(ctl.state), int'(S_RESET));
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check_int("first_fetch_state", int'(ctl.state), int'(S_FETCH));

      foreach (tab[i]) begin
         run_instr(tab[i].op, tab[i].fn, tab[i].z, tab[i].ov, tab[i].d0, pcw, rw, ec);
         check_int({tab[i].name, "_pc_writes"}, pcw, tab[i].n_pcw);
         check_int({tab[i].name, "_reg_writes"}, rw, tab[i].n_rw);
         check_int({tab[i].name, "_cause"}, ec, tab[i].ecause);
      end

      for (int n = 0; n < 60; n++) begin
         int r;
         r = int'($urandom_range(0, 21));
         if (r < 20) {op, fn} = pool[r];
         else begin
            op = 6'($urandom_range(0, 63));
            fn = 6'($urandom_range(0, 63));
         end
         run_instr(op, fn, 1'($urandom), 1'($urandom), 1'($urandom), pcw, rw, ec);
      end

      // mult latency measured from the start pulse to the HI/LO write.
      ctl.opcode = 6'h00; ctl.funct = 6'h18; ctl.div0 = 1'b0; ctl.overflow = 1'b0;
      s = -1; h = -1;
      for (int k = 0; k < 80 && h < 0; k++) begin
         @(negedge clock);
         if (act.muldiv_start) s = k;
         if (act.hilo_write) h = k;
         @(posedge clock);
         #1;
      end
      check_int("mult_start_seen", int'(s >= 0), 1);
      check_int("mult_latency", h - s, MD);

      // Asynchronous reset in the middle of MD_WAIT.
      s = -1;
      for (int k = 0; k < 20 && s < 0; k++) begin
         @(negedge clock);
         if (act.muldiv_start) s = k;
         @(posedge clock);
         #1;
      end
      check_int("md_start_before_reset", int'(s >= 0), 1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_int("in_md_wait", int'(ctl.state), int'(S_MD_WAIT));
      #2;
      reset_n = 1'b0;
      #1;
      check_vec("reset_mid_outputs", act, '0);
      check_int("reset_mid_state", int'(ctl.state), int'(S_RESET));
      @(posedge clock);
      #1;
      check_vec("reset_held_outputs", act, '0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check_int("release_fetch_state", int'(ctl.state), int'(S_FETCH));
      check_int("release_fetch_mem_read", int'(act.mem_read), 1);
      run_instr(6'h00, 6'h20, 0, 0, 0, pcw, rw, ec);
      check_int("post_reset_add_reg_writes", rw, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
